seg_mux: RTL and testbench
==========================

# seg_mux

Display-side consumer of the rotating active-low anode select. It takes the one-hot anode pattern from the scan generator and the four BCD digits from the stopwatch counter, and drives the physical anode and cathode pins of the 4-digit 7-segment display. Its sequential duties are three:
- frame-coherent digit latching, so no tearing is visible;
- ghost blanking on every anode change;
- leading-zero suppression.

## Interface
Parameters:
- GHOST, 16: number of `mclk` cycles all outputs are forced off after each anode change; legal range 0..255.

Ports (one clock; reset is synchronous and active-high):
- mclk  in  1  system clock
- rst  in  1  synchronous active-high reset
- an_in  in  4  anode select from scanner; active-low one-hot; bit 0 is the rightmost digit
- digits  in  16  BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3
- dp_mask  in  4  decimal-point enables, active-high, per digit
- load  in  1  one-cycle strobe that captures digits/dp_mask into the shadow register
- blank_lz  in  1  enables leading-zero blanking
- an  out  4  anode pins, active-low
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low

## Operation
Reset:
- an=4'b1111, seg=7'b1111111, dp=1.
- shadow=0, display=0, an_prev=4'b1111, ghost counter=0.

Shadow register:
- On a `load`=1 edge, shadow <= {digits, dp_mask}.

Display register (frame swap):
- display <= shadow on the edge where an_in differs from an_prev AND an_in==4'b1110.
- If `load` and a frame swap share an edge, display takes the OLD shadow value.

Change detection:
- Every edge, an_prev <= an_in.
- A change (an_in != an_prev) loads the ghost counter with GHOST. The counter then decrements to 0.
- A change during blanking reloads the counter.

Output states:
- BLANK (counter != 0): an=1111, seg=1111111, dp=1.
- DRIVE (counter == 0, an_in valid): an <= an_in; seg and dp are taken from the selected display digit.
- Invalid an_in (not exactly one zero bit): outputs off, as in BLANK, for as long as it persists.

Digit decode (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Values 10..15 show '-' = 0111111.

Leading-zero blanking (blank_lz=1):
- Digit 3 is blanked if d3==0.
- Digit 2 is blanked if d3==d2==0.
- Digit 1 is blanked if d3==d2==d1==0.
- Digit 0 is never blanked.
- A blanked digit has seg=1111111 and dp=1, but its anode is still driven.

dp:
- dp = ~dp_mask bit of the selected digit, unless that digit is blanked.

## Timing
- All outputs are registered. No combinational path runs from inputs to pins.
- Anode change sampled at edge t: outputs are off from edge t+1 through t+GHOST. The new digit appears at edge t+GHOST+1.
- With GHOST=0, the new digit appears at edge t+1 with no blank cycle.
- `load` at edge t: the shadow is valid at t+1. It becomes visible only after the next transition into an_in=1110.
- `rst` asserted mid-blank or mid-frame: reset values apply at the next edge. The first post-reset valid an_in counts as a change.

## Structure
- Package seg_pkg holds:
  - the BCD-to-segment constants;
  - SEG_OFF=7'b1111111, AN_OFF=4'b1111, SEG_DASH=7'b0111111;
  - the default GHOST.
- One sub-module, bcd_to_seg: combinational 4-bit to 7-bit decoder using the seg_pkg constants.
- seg_mux itself contains the shadow/display registers, change detector, ghost counter, and output registers.

## Test plan
- Reset: rst=1 for 2 cycles with arbitrary inputs -> an=1111, seg=1111111, dp=1 throughout.
- Basic drive: GHOST=4; load digits=16'h1234; step an_in 1111->1110 -> frame swaps; an=1111 for 4 cycles, then an=1110, seg=0011001 (4).
- Leading zeros: digits=16'h0070, blank_lz=1 -> digits 3 and 2 show seg=1111111 with anode driven; digit 1 shows 1111000; digit 0 shows 1000000.
- No tearing: load 16'h9999 while an_in=1011 -> digits 2 and 3 still show old values. New values appear only after an_in returns to 1110. Also cover load coincident with the swap edge (old shadow shown).
- Invalid/illegal: an_in=1100 -> outputs off. Digit value 4'hA -> seg=0111111. dp_mask=0001 on digit 0 -> dp=0 only while an=1110.
- Reset mid-blank: rst during the ghost countdown -> all outputs off next edge. After release, a valid an_in yields a full GHOST blank before drive.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 4-digit 7-segment display driver.
//   - Active-low segment patterns for BCD 0..9, the dash shown for 10..15,
//     and the all-off values for cathodes and anodes.
//   - Default ghost-blanking length in mclk cycles.
//   - frame_t: one captured display frame (four BCD digits plus dp enables).
package seg_pkg;

    localparam int GHOST_DEFAULT = 16;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_FIRST = 4'b1110;

    // Cathode order is {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp_mask;
    } frame_t;

endpackage

// File: rtl/seg_mux_if.sv
// seg_mux_if: signal bundle between the scan/counter side and the display driver.
//   an_in    : active-low one-hot anode select from the scanner (bit 0 = rightmost)
//   digits   : four BCD digits, [3:0] = digit 0
//   dp_mask  : per-digit decimal-point enables, active-high
//   load     : one-cycle strobe capturing digits/dp_mask into the shadow frame
//   blank_lz : enables leading-zero suppression
//   an/seg/dp: registered, active-low display pins
// master drives the inputs and observes the pins; slave is the display driver.
interface seg_mux_if;

    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output an_in, digits, dp_mask, load, blank_lz,
        input  an, seg, dp
    );

    modport slave (
        input  an_in, digits, dp_mask, load, blank_lz,
        output an, seg, dp
    );

endinterface

// File: rtl/seg_mux_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low 7-segment decoder.
//   bcd : 4-bit digit value
//   seg : {g,f,e,d,c,b,a}, active-low; values 10..15 render as a dash
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_mux.sv
// seg_mux: drives the anode and cathode pins of a 4-digit 7-segment display.
//   mclk : system clock
//   rst  : synchronous active-high reset
//   bus  : seg_mux_if slave (an_in, digits, dp_mask, load, blank_lz in;
//          an, seg, dp out, all registered and active-low)
// Digits are captured into a shadow frame on load and copied to the display
// frame only when the scan enters digit 0, so a frame never tears. Every anode
// change blanks all outputs for GHOST cycles to hide segment ghosting.
module seg_mux
    import seg_pkg::*;
#(
    parameter int GHOST = GHOST_DEFAULT
) (
    input  logic      mclk,
    input  logic      rst,
    seg_mux_if.slave  bus
);

    localparam logic [7:0] GHOST_LOAD = 8'(GHOST);

    frame_t     shadow;
    frame_t     display;
    logic [3:0] an_prev;
    logic [7:0] ghost_cnt;
    logic [3:0] an_q;
    logic [6:0] seg_q;
    logic       dp_q;

    logic       an_change;
    logic       frame_swap;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [3:0] cur_digit;
    logic       cur_dp_en;
    logic       lz_blank;
    logic [6:0] dec_seg;

    assign an_change  = (bus.an_in != an_prev);
    assign frame_swap = an_change && (bus.an_in == AN_FIRST);

    // The pins follow an_prev rather than an_in: on the edge where the anode
    // changes, the display frame may still be swapping, so the new digit is
    // only shown once both have settled (one edge later at the earliest).
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        case (an_prev)
            4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
            4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
            4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
            4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
            default: begin sel_valid = 1'b0; sel_idx = 2'd0; end
        endcase
    end

    assign cur_digit = display.digits[{sel_idx, 2'b00} +: 4];
    assign cur_dp_en = display.dp_mask[sel_idx];

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (sel_idx)
            2'd3: lz_blank = (display.digits[15:12] == 4'd0);
            2'd2: lz_blank = (display.digits[15:8]  == 8'd0);
            2'd1: lz_blank = (display.digits[15:4]  == 12'd0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank && bus.blank_lz;
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Frame capture, change detection and ghost counter. A load on the swap
    // edge lands in the shadow while the display takes the previous shadow.
    always_ff @(posedge mclk) begin
        if (rst) begin
            shadow    <= '0;
            display   <= '0;
            an_prev   <= AN_OFF;
            ghost_cnt <= '0;
        end else begin
            an_prev <= bus.an_in;
            if (bus.load)
                shadow <= frame_t'{digits: bus.digits, dp_mask: bus.dp_mask};
            if (frame_swap)
                display <= shadow;
            if (an_change)
                ghost_cnt <= GHOST_LOAD;
            else if (ghost_cnt != 8'd0)
                ghost_cnt <= ghost_cnt - 8'd1;
        end
    end

    // Output registers: everything off while blanking or while the anode
    // select is not a clean one-hot pattern.
    always_ff @(posedge mclk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else if ((ghost_cnt != 8'd0) || !sel_valid) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_prev;
            seg_q <= lz_blank ? SEG_OFF : dec_seg;
            dp_q  <= lz_blank ? 1'b1 : ~cur_dp_en;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_mux.sv
// tb_seg_mux: self-checking bench for seg_mux, with one instance at GHOST=4
// and one at GHOST=0 sharing the same stimulus. Inputs sampled on every edge
// are recorded; the expected pins after edge e are derived from that history
// (last reset, last anode change, last frame swap, last load before it).
module tb_seg_mux;

    localparam int MAXE = 1024;

    logic        mclk = 1'b0;
    logic        rst;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        load;
    logic        blank_lz;

    int errors = 0;
    int checks = 0;

    seg_mux_if bus4 ();
    seg_mux_if bus0 ();

    assign bus4.an_in = an_in;   assign bus0.an_in = an_in;
    assign bus4.digits = digits; assign bus0.digits = digits;
    assign bus4.dp_mask = dp_mask; assign bus0.dp_mask = dp_mask;
    assign bus4.load = load;     assign bus0.load = load;
    assign bus4.blank_lz = blank_lz; assign bus0.blank_lz = blank_lz;

    seg_mux #(.GHOST(4)) dut4 (.mclk(mclk), .rst(rst), .bus(bus4));
    seg_mux #(.GHOST(0)) dut0 (.mclk(mclk), .rst(rst), .bus(bus0));

    always #5 mclk = ~mclk;

    // Input history, one entry per rising edge
    logic [3:0]  h_an  [MAXE];
    logic [15:0] h_dig [MAXE];
    logic [3:0]  h_dpm [MAXE];
    bit          h_rst [MAXE];
    bit          h_ld  [MAXE];
    bit          h_blz [MAXE];
    int          edge_cnt = 0;

    always @(posedge mclk) begin
        if (edge_cnt < MAXE) begin
            h_an[edge_cnt]  = an_in;
            h_dig[edge_cnt] = digits;
            h_dpm[edge_cnt] = dp_mask;
            h_rst[edge_cnt] = rst;
            h_ld[edge_cnt]  = load;
            h_blz[edge_cnt] = blank_lz;
        end
        edge_cnt++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [11:0] pk(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    // Anode value the design remembers from before edge k
    function automatic logic [3:0] prev_an(input int k);
        if (k == 0 || h_rst[k-1]) return 4'b1111;
        return h_an[k-1];
    endfunction

    function automatic bit changed(input int k);
        return !h_rst[k] && (h_an[k] != prev_an(k));
    endfunction

    // Expected {an,seg,dp} registered at edge e for a given ghost length
    function automatic logic [11:0] model_out(input int e, input int ghost);
        int r;
        int idx;
        int zeros;
        logic [3:0]  sel;
        logic [15:0] dig;
        logic [3:0]  dpm;
        logic [3:0]  d;
        bit          lz;
        if (h_rst[e]) return 12'hFFF;
        r = e - 1;
        while (r >= 0 && !h_rst[r]) r--;
        for (int k = e - 1; k > r; k--) begin
            if (changed(k)) begin
                if (e - k <= ghost) return 12'hFFF;
                break;
            end
        end
        sel = prev_an(e);
        zeros = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!sel[i]) begin zeros++; idx = i; end
        if (zeros != 1) return 12'hFFF;
        dig = '0;
        dpm = '0;
        for (int s = e - 1; s > r; s--) begin
            if (changed(s) && h_an[s] == 4'b1110) begin
                for (int l = s - 1; l > r; l--) begin
                    if (h_ld[l]) begin dig = h_dig[l]; dpm = h_dpm[l]; break; end
                end
                break;
            end
        end
        d  = dig[4*idx +: 4];
        lz = h_blz[e] && (idx > 0) && ((dig >> (4*idx)) == 16'd0);
        return pk(sel, lz ? 7'b1111111 : seg_of(d), lz ? 1'b1 : ~dpm[idx]);
    endfunction

    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Every cycle: both instances against the history model
    always @(negedge mclk) begin
        if (edge_cnt > 0 && edge_cnt <= MAXE) begin
            check_output($sformatf("model_g4 edge %0d", edge_cnt - 1),
                         {bus4.an, bus4.seg, bus4.dp}, model_out(edge_cnt - 1, 4));
            check_output($sformatf("model_g0 edge %0d", edge_cnt - 1),
                         {bus0.an, bus0.seg, bus0.dp}, model_out(edge_cnt - 1, 0));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] a, input int n);
        an_in = a;
        step(n);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        digits  = d;
        dp_mask = m;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; an_in = 4'b1010; digits = 16'hBEEF; dp_mask = 4'hF;
        load = 1'b1; blank_lz = 1'b1;
        step(2);
        check_output("reset g4", {bus4.an, bus4.seg, bus4.dp}, 12'hFFF);
        check_output("reset g0", {bus0.an, bus0.seg, bus0.dp}, 12'hFFF);
        rst = 1'b0; load = 1'b0; blank_lz = 1'b0;
        apply_stimulus(4'b1111, 2);
        do_load(16'h1234, 4'b0000);
        step(1);

        // Basic drive: swap into 1110 shows digit 0 = 4
        apply_stimulus(4'b1110, 1);
        step(1);
        check_output("g0 drive t+1", {bus0.an, bus0.seg, bus0.dp}, pk(4'b1110, 7'b0011001, 1'b1));
        check_output("g4 blank t+1", {bus4.an, bus4.seg, bus4.dp}, 12'hFFF);
        step(3);
        check_output("g4 blank t+4", {bus4.an, bus4.seg, bus4.dp}, 12'hFFF);
        step(1);
        check_output("g4 drive t+5", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1110, 7'b0011001, 1'b1));

        apply_stimulus(4'b1101, 6);
        check_output("digit1=3", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1101, 7'b0110000, 1'b1));
        apply_stimulus(4'b1011, 6);
        check_output("digit2=2", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1011, 7'b0100100, 1'b1));

        // No tearing: loading mid-frame keeps the old digits visible
        do_load(16'h9999, 4'b0000);
        step(5);
        check_output("no tear d2", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1011, 7'b0100100, 1'b1));
        apply_stimulus(4'b0111, 6);
        check_output("no tear d3", {bus4.an, bus4.seg, bus4.dp}, pk(4'b0111, 7'b1111001, 1'b1));
        apply_stimulus(4'b1110, 6);
        check_output("new frame 9", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1110, 7'b0010000, 1'b1));

        // Load coincident with swap: display takes the older shadow (5555)
        apply_stimulus(4'b1101, 6);
        do_load(16'h5555, 4'b0000);
        step(1);
        an_in = 4'b1110;
        do_load(16'h0070, 4'b0001);
        step(5);
        check_output("swap old shadow", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1110, 7'b0010010, 1'b1));

        // Leading zeros and dp on 0070
        blank_lz = 1'b1;
        apply_stimulus(4'b1101, 6);
        apply_stimulus(4'b1110, 6);
        check_output("lz d0 dp", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1110, 7'b1000000, 1'b0));
        apply_stimulus(4'b1101, 6);
        check_output("lz d1=7", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1101, 7'b1111000, 1'b1));
        apply_stimulus(4'b1011, 6);
        check_output("lz d2 blank", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1011, 7'b1111111, 1'b1));
        apply_stimulus(4'b0111, 6);
        check_output("lz d3 blank", {bus4.an, bus4.seg, bus4.dp}, pk(4'b0111, 7'b1111111, 1'b1));

        // Invalid anode pattern
        apply_stimulus(4'b1100, 6);
        check_output("invalid an", {bus4.an, bus4.seg, bus4.dp}, 12'hFFF);
        check_output("invalid an g0", {bus0.an, bus0.seg, bus0.dp}, 12'hFFF);

        // Non-BCD digit shows a dash
        do_load(16'h00A0, 4'b0000);
        apply_stimulus(4'b1110, 6);
        apply_stimulus(4'b1101, 6);
        check_output("dash", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1101, 7'b0111111, 1'b1));

        // Reset mid-blank, then a full blank before the first drive
        apply_stimulus(4'b1110, 2);
        rst = 1'b1;
        step(1);
        check_output("rst mid-blank", {bus4.an, bus4.seg, bus4.dp}, 12'hFFF);
        rst = 1'b0;
        step(5);
        check_output("post-rst blank", {bus4.an, bus4.seg, bus4.dp}, 12'hFFF);
        step(1);
        check_output("post-rst drive", {bus4.an, bus4.seg, bus4.dp}, pk(4'b1110, 7'b1000000, 1'b1));

        step(2);
        @(negedge mclk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
